// File: rtl/ss_addsub_acc_if.sv
// Signal bundle for ss_addsub_acc: count enable, signed stochastic input streams,
// zero-result sign policy, and the registered output bit, sign, clamp flag and accumulator monitor.
interface ss_addsub_acc_if #(
  parameter int N     = 6,
  parameter int ACC_W = 5
);
  logic             EN;
  logic [N-1:0]     IN;
  logic [N-1:0]     SIGN;
  logic             R_condition;
  logic             OUT;
  logic             SIGN_out;
  logic             SAT;
  logic [ACC_W-1:0] ACC_MON;

  modport master (
    output EN, IN, SIGN, R_condition,
    input  OUT, SIGN_out, SAT, ACC_MON
  );

  modport slave (
    input  EN, IN, SIGN, R_condition,
    output OUT, SIGN_out, SAT, ACC_MON
  );
endinterface

// File: rtl/ss_addsub_acc.sv
// N-input signed stochastic adder/subtractor: the net signed bit count feeds a saturating
// residue accumulator that emits at most one sign-magnitude output bit per cycle.
module ss_addsub_acc #(
  parameter int N        = 6,
  parameter int ACC_W    = 5,
  parameter int DEADBAND = 0
) (
  input logic            CLK,
  input logic            INIT,
  ss_addsub_acc_if.slave bus
);
  localparam int D_W = $clog2(N + 1) + 1;
  localparam int T_W = ACC_W + 1;

  localparam logic signed [T_W-1:0] POS_MAX = T_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [T_W-1:0] NEG_MAX = -POS_MAX;
  localparam logic signed [T_W-1:0] POS_DB  = T_W'(DEADBAND);
  localparam logic signed [T_W-1:0] NEG_DB  = -POS_DB;
  localparam logic signed [T_W-1:0] ONE     = T_W'(1);

  logic signed [ACC_W-1:0] acc;
  logic                    out_q;
  logic                    sign_q;
  logic                    sat_q;

  logic [D_W-1:0]          p_cnt;
  logic [D_W-1:0]          m_cnt;
  logic signed [D_W-1:0]   d;
  logic signed [T_W-1:0]   t;
  logic signed [T_W-1:0]   a;
  logic signed [T_W-1:0]   a_clip;
  logic                    out_nxt;
  logic                    sign_nxt;
  logic                    sat_nxt;

  // NOTE: combinational logic uses blocking '=' so later statements see the updated
  // value (the popcount accumulates); every output gets a default first so no latch forms.
  always_comb begin
    p_cnt = '0;
    m_cnt = '0;
    for (int i = 0; i < N; i++) begin
      p_cnt = p_cnt + D_W'(bus.IN[i] & ~bus.SIGN[i]);
      m_cnt = m_cnt + D_W'(bus.IN[i] & bus.SIGN[i]);
    end
    d = $signed(p_cnt - m_cnt);
    t = $signed({{(T_W - ACC_W){acc[ACC_W-1]}}, acc})
      + $signed({{(T_W - D_W){d[D_W-1]}}, d});

    out_nxt  = 1'b0;
    sign_nxt = bus.R_condition ? sign_q : 1'b0;
    a        = t;
    if (t > POS_DB) begin
      out_nxt  = 1'b1;
      sign_nxt = 1'b0;
      a        = t - ONE;
    end else if (t < NEG_DB) begin
      out_nxt  = 1'b1;
      sign_nxt = 1'b1;
      a        = t + ONE;
    end

    // The most-negative code is never produced, keeping the range symmetric.
    sat_nxt = 1'b0;
    a_clip  = a;
    if (a > POS_MAX) begin
      a_clip  = POS_MAX;
      sat_nxt = 1'b1;
    end else if (a < NEG_MAX) begin
      a_clip  = NEG_MAX;
      sat_nxt = 1'b1;
    end
  end

  // NOTE: registered state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      acc    <= '0;
      out_q  <= 1'b0;
      sign_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (bus.EN) begin
      acc    <= a_clip[ACC_W-1:0];
      out_q  <= out_nxt;
      sign_q <= sign_nxt;
      sat_q  <= sat_nxt;
    end else begin
      out_q  <= 1'b0;
      sat_q  <= 1'b0;
    end
  end

  assign bus.OUT      = out_q;
  assign bus.SIGN_out = sign_q;
  assign bus.SAT      = sat_q;
  assign bus.ACC_MON  = acc;
endmodule

// File: tb/tb_ss_addsub_acc.sv
// Scoreboard bench for ss_addsub_acc: two configurations driven in lockstep, expected
// responses from an integer reference model queued at stimulus time and popped by a monitor.
module tb_ss_addsub_acc;
  localparam int A_N = 4, A_W = 4, A_DB = 0;
  localparam int B_N = 6, B_W = 5, B_DB = 2;
  localparam int A_MAX = (1 << (A_W - 1)) - 1;
  localparam int B_MAX = (1 << (B_W - 1)) - 1;

  typedef struct {
    int acc;
    bit out;
    bit sgn;
    bit sat;
  } st_t;

  logic clk;
  logic init;

  ss_addsub_acc_if #(.N(A_N), .ACC_W(A_W)) ifa ();
  ss_addsub_acc_if #(.N(B_N), .ACC_W(B_W)) ifb ();

  ss_addsub_acc #(.N(A_N), .ACC_W(A_W), .DEADBAND(A_DB)) u_dut_a (
    .CLK (clk),
    .INIT(init),
    .bus (ifa)
  );

  ss_addsub_acc #(.N(B_N), .ACC_W(B_W), .DEADBAND(B_DB)) u_dut_b (
    .CLK (clk),
    .INIT(init),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  st_t st_a, st_b;
  st_t qa[$];
  st_t qb[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: net signed count joins the residue, one unit leaves per emitted bit,
  // and the result is clipped to the symmetric range.
  function automatic st_t model_step(input st_t s, input int d, input bit en, input bit rc,
                                     input int acc_max, input int db);
    st_t r;
    int  t;
    int  v;
    r = s;
    r.out = 1'b0;
    r.sat = 1'b0;
    if (!en) return r;
    t = s.acc + d;
    if (t > db) begin
      r.out = 1'b1;
      r.sgn = 1'b0;
      v = t - 1;
    end else if (t < -db) begin
      r.out = 1'b1;
      r.sgn = 1'b1;
      v = t + 1;
    end else begin
      r.sgn = rc ? s.sgn : 1'b0;
      v = t;
    end
    if (v > acc_max) begin
      v = acc_max;
      r.sat = 1'b1;
    end else if (v < -acc_max) begin
      v = -acc_max;
      r.sat = 1'b1;
    end
    r.acc = v;
    return r;
  endfunction

  task automatic cycle(input bit i_init, input bit i_en, input bit i_rc,
                       input logic [A_N-1:0] a_in, input logic [A_N-1:0] a_sg,
                       input logic [B_N-1:0] b_in, input logic [B_N-1:0] b_sg);
    @(negedge clk);
    init            = i_init;
    ifa.EN          = i_en;
    ifa.R_condition = i_rc;
    ifa.IN          = a_in;
    ifa.SIGN        = a_sg;
    ifb.EN          = i_en;
    ifb.R_condition = i_rc;
    ifb.IN          = b_in;
    ifb.SIGN        = b_sg;
    if (i_init) begin
      st_a = '{default: 0};
      st_b = '{default: 0};
    end else begin
      st_a = model_step(st_a, $countones(a_in & ~a_sg) - $countones(a_in & a_sg),
                        i_en, i_rc, A_MAX, A_DB);
      st_b = model_step(st_b, $countones(b_in & ~b_sg) - $countones(b_in & b_sg),
                        i_en, i_rc, B_MAX, B_DB);
    end
    qa.push_back(st_a);
    qb.push_back(st_b);
  endtask

  // Monitor: one output word per DUT per clock edge, compared against the queued expectation.
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a.OUT", int'(ifa.OUT), int'(e.out));
        check("a.SIGN_out", int'(ifa.SIGN_out), int'(e.sgn));
        check("a.SAT", int'(ifa.SAT), int'(e.sat));
        check("a.ACC_MON", int'($signed(ifa.ACC_MON)), e.acc);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b.OUT", int'(ifb.OUT), int'(e.out));
        check("b.SIGN_out", int'(ifb.SIGN_out), int'(e.sgn));
        check("b.SAT", int'(ifb.SAT), int'(e.sat));
        check("b.ACC_MON", int'($signed(ifb.ACC_MON)), e.acc);
      end
    end
  end

  initial begin
    init            = 1'b1;
    ifa.EN          = 1'b0;
    ifa.R_condition = 1'b0;
    ifa.IN          = '0;
    ifa.SIGN        = '0;
    ifb.EN          = 1'b0;
    ifb.R_condition = 1'b0;
    ifb.IN          = '0;
    ifb.SIGN        = '0;
    st_a = '{default: 0};
    st_b = '{default: 0};

    // Reset held with random activity on every input.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            6'($urandom), 6'($urandom));
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Exact cancellation of a positive and a negative bit in the same cycle.
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 6'b000011, 6'b000010);
    // Alternating single positive / single negative bit.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cycle(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0010, 6'b000001, 6'b000010);
      else            cycle(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 6'b000010, 6'b000010);
    end

    // Saturation, then drain with no input.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 6'b111111, 6'b000000);
    for (int i = 0; i < 18; i++)
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Deadband: repeated single negative bit, then saturate negative and drain.
    cycle(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 6'b000001, 6'b000001);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 6'b111111, 6'b111111);
    for (int i = 0; i < 18; i++)
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Zero-result sign policy, both settings.
    for (int rc = 1; rc >= 0; rc--) begin
      cycle(1'b1, 1'b1, 1'(rc), '0, '0, '0, '0);
      cycle(1'b0, 1'b1, 1'(rc), 4'b0001, 4'b0000, 6'b000111, 6'b000000);
      cycle(1'b0, 1'b1, 1'(rc), 4'b0001, 4'b0001, 6'b111111, 6'b111111);
      for (int i = 0; i < 3; i++)
        cycle(1'b0, 1'b1, 1'(rc), '0, '0, '0, '0);
    end

    // Freeze: build residue, then EN low with active inputs.
    cycle(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 6'b111111, 6'b000000);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom),
            6'($urandom), 6'($urandom));

    // Asynchronous reset between edges clears state before the next edge.
    @(posedge clk);
    #4;
    init = 1'b1;
    #1;
    check("async.a.ACC_MON", int'($signed(ifa.ACC_MON)), 0);
    check("async.a.OUT", int'(ifa.OUT), 0);
    check("async.b.ACC_MON", int'($signed(ifb.ACC_MON)), 0);
    check("async.b.OUT", int'(ifb.OUT), 0);
    st_a = '{default: 0};
    st_b = '{default: 0};
    cycle(1'b1, 1'b1, 1'b0, 4'($urandom), 4'($urandom), 6'($urandom), 6'($urandom));

    // Random traffic with occasional EN drops and resets.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
            4'($urandom), 4'($urandom), 6'($urandom), 6'($urandom));

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++)
      @(posedge clk);
    #3;
    n_tests++;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
